mul_ctrl: RTL

Control-path FSM for the repeated-addition multiplier: sequences register loads, accumulation and counter decrements in the datapath and consumes the 16-bit zero-detect status `eq` from that datapath. Sits beside the datapath (A/B/P registers, adder, down-counter, zero detector) and presents a start/done handshake to the host. It never sees operand data; it drives control strobes and reacts only to `eq`.

---
 rtl/mul_ctrl_pkg.sv | 16 +
 rtl/mul_ctrl_tmo.sv | 23 ++
 rtl/mul_ctrl.sv | 95 +++++++++
 3 files changed

// File: rtl/mul_ctrl_pkg.sv
// Shared types and defaults for the repeated-addition multiplier control path.
package mul_ctrl_pkg;

  localparam int unsigned STATE_W     = 3;
  localparam int unsigned TMO_W_DEF   = 16;
  localparam logic [15:0] TMO_MAX_DEF = 16'hFFFF;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 3'd0,
    LDA  = 3'd1,
    LDB  = 3'd2,
    ACC  = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/mul_ctrl_tmo.sv
// Accumulate-cycle timeout counter; only instantiated when MUL_CTRL_TIMEOUT_EN is defined.
module mul_ctrl_tmo #(
  parameter int unsigned      TMO_W   = 16,
  parameter logic [TMO_W-1:0] TMO_MAX = '1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic hit
);

  logic [TMO_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + TMO_W'(1);
  end

  assign hit = (cnt == TMO_MAX);

endmodule

// File: rtl/mul_ctrl.sv
// Control FSM for the repeated-addition multiplier datapath.
// Optional ACC timeout abort is enabled by defining MUL_CTRL_TIMEOUT_EN.
module mul_ctrl
  import mul_ctrl_pkg::*;
#(
  parameter int unsigned      TMO_W   = TMO_W_DEF,
  parameter logic [TMO_W-1:0] TMO_MAX = TMO_W'(TMO_MAX_DEF)
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic eq,
  output logic lda,
  output logic ldb,
  output logic clrp,
  output logic ldp,
  output logic decb,
  output logic busy,
  output logic done,
  output logic err
);

  state_t state, state_nxt;
  logic   tmo_hit;
  logic   acc_run;

  // Accumulate only while B is nonzero and the timeout has not fired.
  assign acc_run = (state == ACC) && !eq && !tmo_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = start ? LDA : IDLE;
      LDA:     state_nxt = LDB;
      LDB:     state_nxt = ACC;
      ACC:     state_nxt = (eq || tmo_hit) ? DONE : ACC;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    lda  = 1'b0;
    ldb  = 1'b0;
    clrp = 1'b0;
    ldp  = 1'b0;
    decb = 1'b0;
    done = 1'b0;
    busy = (state != IDLE);
    case (state)
      LDA: lda = 1'b1;
      LDB: begin
        ldb  = 1'b1;
        clrp = 1'b1;
      end
      ACC: begin
        ldp  = acc_run;
        decb = acc_run;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

`ifdef MUL_CTRL_TIMEOUT_EN
  mul_ctrl_tmo #(
    .TMO_W   (TMO_W),
    .TMO_MAX (TMO_MAX)
  ) u_tmo (
    .clk (clk),
    .rst (rst),
    .clr (state == LDB),
    .inc (acc_run),
    .hit (tmo_hit)
  );

  // Sticky abort flag, cleared when the next operation is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  err <= 1'b0;
    else if (state == IDLE && start)          err <= 1'b0;
    else if (state == ACC && !eq && tmo_hit)  err <= 1'b1;
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^{TMO_MAX, TMO_W};
  assign tmo_hit    = 1'b0;
  assign err        = 1'b0;
`endif

endmodule
